// File: rtl/shift_arbiter.sv
// Two-requester front end for a shared combinational barrel shifter. It grants one request,
// registers the shifter result and returns it tagged with the owner. Optional: SHIFT_ARB_BYPASS_EN.
module shift_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [2:0]  req0_opcode,
   input  logic        req0_carry,
   input  logic [4:0]  req0_shift,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [2:0]  req1_opcode,
   input  logic        req1_carry,
   input  logic [4:0]  req1_shift,
   output logic [31:0] sh_a,
   output logic [2:0]  sh_opcode,
   output logic        sh_carry_in,
   output logic [4:0]  sh_shift,
   input  logic [31:0] sh_a_out,
   input  logic        sh_carry_out,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_result,
   output logic        resp_carry
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_id_q, resp_id_d;
   logic [31:0] resp_result_q, resp_result_d;
   logic        resp_carry_q, resp_carry_d;

   logic        can_accept;
   logic        grant_any;
   logic        grant_id;

   // Grant selection and shifter input steering
   always_comb begin
`ifdef SHIFT_ARB_BYPASS_EN
      // A retiring response frees the output register in the same cycle.
      can_accept = (state_q == IDLE) || resp_ready;
`else
      can_accept = (state_q == IDLE);
`endif
      grant_any = can_accept && (req0_valid || req1_valid) && !reset;
      if (req0_valid && req1_valid) grant_id = FIXED_PRIO ? 1'b0 : prio_q;
      else                          grant_id = req1_valid;

      req0_ready = grant_any && !grant_id;
      req1_ready = grant_any && grant_id;

      sh_a        = grant_id ? req1_a      : req0_a;
      sh_opcode   = grant_id ? req1_opcode : req0_opcode;
      sh_carry_in = grant_id ? req1_carry  : req0_carry;
      sh_shift    = grant_id ? req1_shift  : req0_shift;
   end

   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_carry_d  = resp_carry_q;

      if (state_q == HOLD && resp_ready) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
      end
      // A grant (from IDLE, or from HOLD when bypass retires the old response) overrides the retire.
      if (grant_any) begin
         state_d       = HOLD;
         resp_valid_d  = 1'b1;
         resp_id_d     = grant_id;
         resp_result_d = sh_a_out;
         resp_carry_d  = sh_carry_out;
         if (!FIXED_PRIO) prio_d = ~grant_id;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         prio_q        <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= 32'h0;
         resp_carry_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_carry_q  <= resp_carry_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_carry  = resp_carry_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance share the stimulus;
// a cycle-level reference model predicts grants and responses. Honours SHIFT_ARB_BYPASS_EN.
module tb_shift_arbiter;
`ifdef SHIFT_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic v0, v1, c0, c1, rr;
   logic [31:0] a0, a1;
   logic [2:0]  op0, op1;
   logic [4:0]  s0, s1;

   logic        rdy0 [2], rdy1 [2], shci [2], shco [2], rv [2], rid [2], rc [2];
   logic [31:0] sha [2], sho [2], rres [2];
   logic [2:0]  shop [2];
   logic [4:0]  shs [2];

   int n_tests = 0, n_fail = 0;
   int gcnt [2][2];
   bit acc0, acc1;

   // Reference state: one response register per instance plus the round-robin pointer
   bit          m_hold [2], m_prio [2], m_id [2], m_car [2];
   logic [31:0] m_res [2];

   always #5 clk = ~clk;

   // Behavioural barrel shifter standing in for the external instance
   function automatic logic [32:0] shf(input logic [31:0] a, input logic [2:0] op,
                                      input logic c, input logic [4:0] s);
      int n;
      logic [31:0] r;
      n = int'(s);
      r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      case (op)
         3'd0: return (n == 0) ? {c, a} : {a[32 - n], a << n};
         3'd1: return (n == 0) ? {c, a} : {a[n - 1], a >> n};
         3'd2: return (n == 0) ? {c, a} : {a[n - 1], 32'($signed(a) >>> n)};
         3'd3: return (n == 0) ? {c, a} : {r[31], r};
         3'd4: return {a[0], c, a[31:1]};
         default: return {~c, ~a};
      endcase
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_sh
      assign {shco[k], sho[k]} = shf(sha[k], shop[k], shci[k], shs[k]);
   end

   shift_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_opcode(op0), .req0_carry(c0), .req0_shift(s0),
      .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_opcode(op1), .req1_carry(c1), .req1_shift(s1),
      .sh_a(sha[0]), .sh_opcode(shop[0]), .sh_carry_in(shci[0]), .sh_shift(shs[0]),
      .sh_a_out(sho[0]), .sh_carry_out(shco[0]),
      .resp_valid(rv[0]), .resp_ready(rr), .resp_id(rid[0]), .resp_result(rres[0]), .resp_carry(rc[0]));

   shift_arbiter #(.FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_opcode(op0), .req0_carry(c0), .req0_shift(s0),
      .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_opcode(op1), .req1_carry(c1), .req1_shift(s1),
      .sh_a(sha[1]), .sh_opcode(shop[1]), .sh_carry_in(shci[1]), .sh_shift(shs[1]),
      .sh_a_out(sho[1]), .sh_carry_out(shco[1]),
      .resp_valid(rv[1]), .resp_ready(rr), .resp_id(rid[1]), .resp_result(rres[1]), .resp_carry(rc[1]));

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         m_hold[k] = 0; m_prio[k] = 0; m_id[k] = 0; m_car[k] = 0; m_res[k] = '0;
      end
   endtask

   // Inputs are set just after a falling edge; check mid-low-phase, advance model, wait for next fall.
   task automatic cyc();
      bit can, any, gid;
      logic [32:0] e;
      string t;
      #1;
      for (int k = 0; k < 2; k++) begin
         t = (k == 0) ? "rr" : "fix";
         chk({t, ".resp_valid"},  33'(rv[k]),   33'(m_hold[k]));
         chk({t, ".resp_id"},     33'(rid[k]),  33'(m_id[k]));
         chk({t, ".resp_result"}, 33'(rres[k]), 33'(m_res[k]));
         chk({t, ".resp_carry"},  33'(rc[k]),   33'(m_car[k]));
         can = !reset && (!m_hold[k] || (BYP && rr));
         any = can && (v0 || v1);
         gid = (v0 && v1) ? ((k == 1) ? 1'b0 : m_prio[k]) : v1;
         chk({t, ".req0_ready"}, 33'(rdy0[k]), 33'(any && !gid));
         chk({t, ".req1_ready"}, 33'(rdy1[k]), 33'(any && gid));
         if (any) begin
            chk({t, ".sh_a"},      33'(sha[k]),  33'(gid ? a1 : a0));
            chk({t, ".sh_opcode"}, 33'(shop[k]), 33'(gid ? op1 : op0));
            chk({t, ".sh_carry"},  33'(shci[k]), 33'(gid ? c1 : c0));
            chk({t, ".sh_shift"},  33'(shs[k]),  33'(gid ? s1 : s0));
            gcnt[k][gid]++;
         end
         if (k == 0) begin acc0 = any && !gid; acc1 = any && gid; end
         if (!reset) begin
            if (m_hold[k] && rr) m_hold[k] = 0;
            if (any) begin
               e = gid ? shf(a1, op1, c1, s1) : shf(a0, op0, c0, s0);
               m_hold[k] = 1; m_id[k] = gid; m_res[k] = e[31:0]; m_car[k] = e[32];
               if (k == 0) m_prio[k] = !gid;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int f0, f1;
      reset = 1; rr = 0; mreset();
      v0 = 1; v1 = 1; a0 = 32'h1234; a1 = 32'h5678; op0 = 0; op1 = 1; c0 = 0; c1 = 0; s0 = 1; s1 = 2;
      for (int k = 0; k < 2; k++) begin gcnt[k][0] = 0; gcnt[k][1] = 0; end
      @(negedge clk);
      cyc(); cyc();                                  // readies must stay low under reset
      reset = 0;

      // Single LSL request on requester 0
      v1 = 0; v0 = 1; a0 = 32'h8000_0001; op0 = 3'd0; c0 = 0; s0 = 5'd4;
      cyc();
      chk("tp_lsl_ready", 33'(acc0), 33'(1));
      v0 = 0;
      cyc();
      chk("tp_lsl_result", 33'(rres[0]), 33'h10);
      chk("tp_lsl_id", 33'(rid[0]), 33'(0));

      // Backpressure: response held, both requesters waiting
      v0 = 1; v1 = 1; a0 = 32'hdead_beef; op0 = 3'd3; s0 = 5'd7; a1 = 32'h0f0f_0001; op1 = 3'd2; s1 = 5'd31;
      repeat (5) cyc();
      chk("bp_result_stable", 33'(rres[0]), 33'h10);
      rr = 1;
      cyc();
      rr = 0;
      cyc();
      v0 = 0; v1 = 0; rr = 1;
      cyc(); cyc();

      // RRX through requester 1
      rr = 0; v1 = 1; a1 = 32'h0000_0003; op1 = 3'd4; c1 = 1; s1 = 5'd9;
      cyc();
      v1 = 0;
      cyc();
      chk("tp_rrx_result", 33'(rres[0]), 33'h8000_0001);
      chk("tp_rrx_carry", 33'(rc[0]), 33'(1));
      chk("tp_rrx_id", 33'(rid[0]), 33'(1));
      rr = 1; cyc();

      // Reset while a response is held
      rr = 0; v0 = 1; v1 = 0; a0 = 32'h4; op0 = 3'd1; s0 = 5'd1;
      cyc();
      reset = 1;
      #1;
      chk("rst_hold_rv_rr", 33'(rv[0]), 33'(0));
      chk("rst_hold_rv_fix", 33'(rv[1]), 33'(0));
      mreset();
      cyc();
      reset = 0;

      // Both requesters always valid: round-robin alternates, fixed priority never serves 1
      v0 = 1; v1 = 1; rr = 1;
      f0 = gcnt[1][0]; f1 = gcnt[1][1];
      cyc();
      chk("rst_first_grant_req0", 33'(acc0), 33'(1));
      repeat (BYP ? 7 : 15) cyc();
      chk("fix_req0_grants", 33'(gcnt[1][0] - f0), 33'(8));
      chk("fix_req1_grants", 33'(gcnt[1][1] - f1), 33'(0));
      v0 = 0; v1 = 0; cyc();

      // Randomized traffic; a waiting request keeps its fields until the round-robin unit takes it
      repeat (600) begin
         if (!v0 || acc0) begin
            v0 = 1'($urandom_range(0, 1)); a0 = $urandom; op0 = 3'($urandom_range(0, 7));
            c0 = 1'($urandom_range(0, 1)); s0 = 5'($urandom_range(0, 31));
         end
         if (!v1 || acc1) begin
            v1 = 1'($urandom_range(0, 1)); a1 = $urandom; op1 = 3'($urandom_range(0, 7));
            c1 = 1'($urandom_range(0, 1)); s1 = 5'($urandom_range(0, 31));
         end
         rr = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single combinational barrel shifter between two requesters.
  - Requester 0: execute-stage operand-2 path.
  - Requester 1: load-data alignment unit.
- Accepts one request at a time through a valid/ready handshake and drives the shifter's input ports.
- Registers the shifter result and carry, then returns them on a valid/ready response channel tagged with the requester ID.
- Sits between the execute-stage muxes and the shifter instance; the shifter itself is instantiated outside this block.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a shift request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_a  input  32  operand
- req0_opcode  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX
- req0_carry  input  1  carry in
- req0_shift  input  5  shift amount
- req1_valid, req1_ready, req1_a, req1_opcode, req1_carry, req1_shift  same as req0_*, for requester 1
- sh_a  output  32  to shifter operand
- sh_opcode  output  3  to shifter opcode
- sh_carry_in  output  1  to shifter carry in
- sh_shift  output  5  to shifter amount
- sh_a_out  input  32  shifter result
- sh_carry_out  input  1  shifter carry out
- resp_valid  output  1  response held
- resp_ready  input  1  consumer takes response
- resp_id  output  1  requester that owns the response
- resp_result  output  32  registered shift result
- resp_carry  output  1  registered carry out

Behaviour:
- Clock and reset are fixed: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, resp_valid = 0, resp_id = 0, resp_result = 0, resp_carry = 0.
  - Priority pointer prio = 0.
  - req*_ready = 0 while reset is asserted.
- FSM states: IDLE, HOLD.
- IDLE, grant selection (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by prio is granted (requester 0 when FIXED_PRIO=1).
- IDLE, outputs:
  - reqN_ready = 1 for the granted requester only; the other requester's ready = 0.
  - sh_* carry the granted requester's fields.
  - With no grant, sh_* carry req0 fields; the values are don't-care.
- IDLE, on the clock edge with a grant:
  - Capture sh_a_out into resp_result and sh_carry_out into resp_carry.
  - resp_id = granted index; resp_valid = 1; state -> HOLD.
  - prio = ~granted index, unless FIXED_PRIO=1.
- IDLE with no valid requester: stay in IDLE; registers unchanged.
- HOLD:
  - Both req*_ready = 0.
  - resp_* stay stable until resp_ready = 1.
  - On the edge with resp_ready = 1: resp_valid = 0, state -> IDLE.
  - resp_result, resp_carry and resp_id keep their last values.
- Latency and throughput:
  - Request accept edge to resp_valid high: 1 cycle.
  - Throughput: 1 operation per 2 cycles.
- Opcodes 5–7 are forwarded unmodified; the result is whatever the shifter returns.
- A requester must hold all of its fields stable while valid=1 and ready=0. The block does not check this.
- A valid dropped before ready is not an error; the request is simply never granted.
- Reset asserted in HOLD: the pending response is discarded and the block returns to IDLE immediately (asynchronous).

Optional Feature:
- Macro: SHIFT_ARB_BYPASS_EN.
- When defined:
  - In HOLD with resp_ready = 1, the block performs IDLE grant selection in the same cycle and asserts the winner's ready.
  - On that edge the old response retires and the new result is captured; resp_valid stays 1 and state stays HOLD.
  - Sustained throughput becomes 1 operation per cycle.
- When undefined: behaviour is exactly as described above, with no ready in HOLD.

Test Plan:
- Single request: req0 a=0x80000001, LSL, shift=4 -> req0_ready=1 in the same cycle; next cycle resp_valid=1, resp_id=0, resp_result=0x00000010.
- Round-robin: both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; every response's id matches its requester.
- FIXED_PRIO=1 with both valid for 4 operations -> all four grants go to requester 0; req1_ready stays 0.
- Backpressure: resp_ready=0 for 5 cycles after a response -> resp_result stays stable, both readies stay 0; resp_ready=1 -> the next request is granted on the following cycle.
- RRX via req1: a=0x00000003, carry=1 -> resp_result=0x80000001, resp_carry=1, resp_id=1.
- Reset while in HOLD -> resp_valid=0 immediately and prio=0; the next grant with both valid goes to requester 0.
- With SHIFT_ARB_BYPASS_EN defined: both requesters valid, resp_ready=1 -> one response per cycle with resp_valid held at 1 throughout.
